// File: rtl/wb_single_master.sv
`default_nettype none
// ============================================================================
// Module      : wb_single_master
// Description : Single-outstanding Wishbone classic master with retry,
//               timeout and a valid/ready command/response front end.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_single_master #(
    parameter int WB_ADR_WIDTH   = 3,
    parameter int WB_DAT_WIDTH   = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETRY_MAX      = 3
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst_n,
    input  logic                    cmd_valid_i,
    input  logic                    cmd_we_i,
    input  logic [WB_ADR_WIDTH-1:0] cmd_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] cmd_dat_i,
    output logic                    cmd_ready_o,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WB_DAT_WIDTH-1:0] rsp_dat_o,
    output logic [1:0]              rsp_status_o,
    output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);

    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int RTY_W = ($clog2(RETRY_MAX + 1) > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUS     = 2'd1;
    localparam logic [1:0] ST_BACKOFF = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [1:0] STS_OK    = 2'b00;
    localparam logic [1:0] STS_ERR   = 2'b01;
    localparam logic [1:0] STS_TMO   = 2'b10;
    localparam logic [1:0] STS_RTYX  = 2'b11;

    logic [1:0]              state_q,      state_d;
    logic                    cyc_q,        cyc_d;
    logic                    we_q,         we_d;
    logic [WB_ADR_WIDTH-1:0] adr_q,        adr_d;
    logic [WB_DAT_WIDTH-1:0] dat_q,        dat_d;
    logic                    rsp_valid_q,  rsp_valid_d;
    logic [WB_DAT_WIDTH-1:0] rsp_dat_q,    rsp_dat_d;
    logic [1:0]              rsp_status_q, rsp_status_d;
    logic [TMO_W-1:0]        tmo_cnt_q,    tmo_cnt_d;
    logic [RTY_W-1:0]        rty_cnt_q,    rty_cnt_d;

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        tmo_cnt_d    = tmo_cnt_q;
        rty_cnt_d    = rty_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d      = cmd_we_i;
                    adr_d     = cmd_adr_i;
                    dat_d     = cmd_dat_i;
                    tmo_cnt_d = '0;
                    rty_cnt_d = '0;
                    cyc_d     = 1'b1;
                    state_d   = ST_BUS;
                end
            end
            ST_BUS: begin
                // Slave responses only count while the strobe is asserted.
                if (cyc_q) begin
                    if (wb_ack_i) begin
                        cyc_d        = 1'b0;
                        rsp_dat_d    = we_q ? '0 : wb_dat_i;
                        rsp_status_d = STS_OK;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end else if (wb_err_i) begin
                        cyc_d        = 1'b0;
                        rsp_dat_d    = '0;
                        rsp_status_d = STS_ERR;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end else if (wb_rty_i) begin
                        cyc_d = 1'b0;
                        if (rty_cnt_q < RTY_LIMIT) begin
                            rty_cnt_d = rty_cnt_q + 1'b1;
                            tmo_cnt_d = '0;
                            state_d   = ST_BACKOFF;
                        end else begin
                            rsp_dat_d    = '0;
                            rsp_status_d = STS_RTYX;
                            rsp_valid_d  = 1'b1;
                            state_d      = ST_RESP;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        cyc_d        = 1'b0;
                        rsp_dat_d    = '0;
                        rsp_status_d = STS_TMO;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
            end
            ST_BACKOFF: begin
                cyc_d   = 1'b1;
                state_d = ST_BUS;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= STS_OK;
            tmo_cnt_q    <= '0;
            rty_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rty_cnt_q    <= rty_cnt_d;
        end
    end

    assign cmd_ready_o  = (state_q == ST_IDLE);
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_we_o      = we_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_cti_o     = 3'b000;
    assign wb_bte_o     = 2'b00;

endmodule
`default_nettype wire

// File: doc/wb_single_master.md
WB_SINGLE_MASTER -- requirements
Module: wb_single_master

Interface
REQ-001 SHALL have parameter WB_ADR_WIDTH, default 3, Wishbone address width.
REQ-002 SHALL have parameter WB_DAT_WIDTH, default 8, Wishbone data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of cycles to wait for termination per bus attempt.
REQ-004 SHALL have parameter RETRY_MAX, default 3, the maximum number of re-issues after wb_rty_i.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: wb_clk  input  1  clock; wb_rst_n  input  1  reset, asserted low.
REQ-006 SHALL have command inputs: cmd_valid_i  input  1  command present; cmd_we_i  input  1  1=write; cmd_adr_i  input  WB_ADR_WIDTH  target address; cmd_dat_i  input  WB_DAT_WIDTH  write data.
REQ-007 SHALL have cmd_ready_o  output  1  command accepted this cycle when high with cmd_valid_i.
REQ-008 SHALL have response ports: rsp_valid_o  output  1  response present; rsp_ready_i  input  1  response consumed; rsp_dat_o  output  WB_DAT_WIDTH  read data; rsp_status_o  output  2  00 ok, 01 err, 10 timeout, 11 retry exhausted.
REQ-009 SHALL have Wishbone master outputs: wb_adr_o WB_ADR_WIDTH; wb_dat_o WB_DAT_WIDTH; wb_we_o 1; wb_cyc_o 1; wb_stb_o 1; wb_cti_o 3 (constant 000); wb_bte_o 2 (constant 00).
REQ-010 SHALL have Wishbone master inputs: wb_dat_i WB_DAT_WIDTH; wb_ack_i 1; wb_err_i 1; wb_rty_i 1.

Function
REQ-011 SHALL implement states IDLE, BUS, BACKOFF, RESP. All outputs SHALL be registered, except cmd_ready_o, which SHALL equal (state==IDLE).
REQ-012 In IDLE, on cmd_valid_i&cmd_ready_o, SHALL latch we/adr/dat, clear the retry and timeout counters, and enter BUS; wb_cyc_o/wb_stb_o SHALL be high from the next cycle.
REQ-013 In BUS, wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o and wb_we_o SHALL be held stable until termination.
REQ-014 Termination priority when inputs coincide SHALL be ack > err > rty; inputs SHALL only be sampled while wb_stb_o is high.
REQ-015 On wb_ack_i, SHALL drop cyc/stb on the same clock edge, capture wb_dat_i into rsp_dat_o for reads (0 for writes), set status 00, and enter RESP.
REQ-016 On wb_err_i, SHALL drop cyc/stb, set rsp_dat_o=0 and status 01, and enter RESP.
REQ-017 On wb_rty_i with retry count < RETRY_MAX, SHALL increment the retry count, clear the timeout counter, and enter BACKOFF with cyc/stb low for exactly one cycle, then return to BUS.
REQ-018 On wb_rty_i with retry count == RETRY_MAX, SHALL drop cyc/stb, set status 11, and enter RESP.
REQ-019 The timeout counter SHALL increment each BUS cycle without termination; when it reaches TIMEOUT_CYCLES-1 without termination, SHALL drop cyc/stb, set status 10 and rsp_dat_o=0, and enter RESP. Termination on that same cycle SHALL take precedence over timeout.
REQ-020 In RESP, rsp_valid_o SHALL be high and rsp_dat_o/rsp_status_o stable until rsp_valid_o&rsp_ready_i, then the block SHALL enter IDLE; at most one transaction SHALL be outstanding.
REQ-021 Latency with a slave that acks one cycle after stb: command accept at cycle N, stb at N+1, ack at N+2, rsp_valid_o at N+3.
REQ-022 Counters SHALL be sized to hold TIMEOUT_CYCLES and RETRY_MAX without wrap.

Reset
REQ-023 While wb_rst_n is low, SHALL immediately force state=IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, rsp_valid_o=0, rsp_dat_o=0, rsp_status_o=00, and all counters=0.
REQ-024 Reset asserted mid-BUS or mid-RESP SHALL abandon the transaction with no response; the first command after reset release SHALL be accepted normally.

Verification
REQ-025 Write: cmd we=1 adr=0 dat=0xA5; 1-cycle-ack slave -> one stb cycle with adr=0, dat=0xA5, we=1; rsp status 00 at N+3.
REQ-026 Read: slave returns 0x3C on ack at adr=1 -> rsp_dat_o=0x3C, status 00; with rsp_ready_i held low 5 cycles, response held stable and cmd_ready_o=0.
REQ-027 Retry: slave asserts rty twice, then ack -> three stb assertions, each separated by exactly one low cycle; status 00.
REQ-028 Retry exhausted: slave always asserts rty, RETRY_MAX=3 -> four stb assertions, then status 11.
REQ-029 Timeout: no response, TIMEOUT_CYCLES=8 -> stb high exactly 8 cycles, then status 10; simultaneous ack+err -> status 00.
REQ-030 Reset: wb_rst_n pulsed low during BUS -> cyc/stb low asynchronously, no rsp_valid_o; next command completes with status 00.
